// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: frame sequencer for the pixel array.
// Steps IDLE -> ERASE -> EXPOSE -> CONVERT -> READ. It drives the phase strobes,
// the shared ADC ramp count and the one-hot row select used during readout.
// Optional macro PIXEL_CTRL_GRAY_COUNT_EN: when it is defined, count is Gray-coded.
// Every output is registered from the next-state decode. No input reaches an
// output through combinational logic.
module pixel_frame_ctrl #(
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int COUNTER_WIDTH = 8,
    parameter int NUM_ROWS      = 2,
    parameter int ROW_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    output logic                     busy,
    output logic                     erase,
    output logic                     expose,
    output logic                     convert,
    output logic                     read,
    output logic [NUM_ROWS-1:0]      rowSel,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     frame_done
);

    localparam int CONV_CYCLES = 1 << COUNTER_WIDTH;
    localparam int READ_CYCLES = NUM_ROWS * ROW_CYCLES;
    localparam int MAX_A       = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int MAX_B       = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
    localparam int MAX_CYC     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PW          = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t                   r_state;
    state_t                   w_nxt_state;
    logic [PW-1:0]            r_cnt;
    logic [PW-1:0]            w_nxt_cnt;
    logic                     w_last;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_nxt_count;
    logic [COUNTER_WIDTH-1:0] w_conv_bin;
    logic [NUM_ROWS-1:0]      r_rowsel;
    logic [NUM_ROWS-1:0]      w_nxt_rowsel;
    logic                     r_busy, r_erase, r_expose, r_convert, r_read, r_frame_done;

`ifdef PIXEL_CTRL_GRAY_COUNT_EN
    function automatic logic [COUNTER_WIDTH-1:0] f_encode(input logic [COUNTER_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction
`else
    function automatic logic [COUNTER_WIDTH-1:0] f_encode(input logic [COUNTER_WIDTH-1:0] bin);
        return bin;
    endfunction
`endif

    // Next-state and phase-counter logic. The counter restarts at every phase change.
    always_comb begin
        w_nxt_state = r_state;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_nxt_state = S_ERASE;
            end
            S_ERASE: begin
                w_last = (r_cnt == PW'(ERASE_CYCLES - 1));
                if (w_last) w_nxt_state = S_EXPOSE;
            end
            S_EXPOSE: begin
                w_last = (r_cnt == PW'(EXPOSE_CYCLES - 1));
                if (w_last) w_nxt_state = S_CONVERT;
            end
            S_CONVERT: begin
                w_last = (r_cnt == PW'(CONV_CYCLES - 1));
                if (w_last) w_nxt_state = S_READ;
            end
            S_READ: begin
                w_last = (r_cnt == PW'(READ_CYCLES - 1));
                if (w_last) w_nxt_state = continuous ? S_ERASE : S_IDLE;
            end
            default: w_nxt_state = S_IDLE;
        endcase
        if ((w_nxt_state != r_state) || (w_nxt_state == S_IDLE))
            w_nxt_cnt = '0;
        else
            w_nxt_cnt = r_cnt + PW'(1);
    end

    // Ramp count and row select. Both are decoded from the upcoming state and counter.
    always_comb begin
        w_conv_bin   = w_nxt_cnt[COUNTER_WIDTH-1:0];
        w_nxt_count  = '0;
        w_nxt_rowsel = '0;
        case (w_nxt_state)
            S_CONVERT: w_nxt_count = f_encode(w_conv_bin);
            S_READ: begin
                w_nxt_count = r_count;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if ((int'(w_nxt_cnt) >= r * ROW_CYCLES) && (int'(w_nxt_cnt) < (r + 1) * ROW_CYCLES))
                        w_nxt_rowsel[r] = 1'b1;
                end
            end
            default: w_nxt_count = '0;
        endcase
    end

    // FSM state, phase counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_count      <= '0;
            r_rowsel     <= '0;
            r_busy       <= 1'b0;
            r_erase      <= 1'b0;
            r_expose     <= 1'b0;
            r_convert    <= 1'b0;
            r_read       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_count      <= w_nxt_count;
            r_rowsel     <= w_nxt_rowsel;
            r_busy       <= (w_nxt_state != S_IDLE);
            r_erase      <= (w_nxt_state == S_ERASE);
            r_expose     <= (w_nxt_state == S_EXPOSE);
            r_convert    <= (w_nxt_state == S_CONVERT);
            r_read       <= (w_nxt_state == S_READ);
            r_frame_done <= (r_state == S_READ) && w_last;
        end
    end

    assign busy       = r_busy;
    assign erase      = r_erase;
    assign expose     = r_expose;
    assign convert    = r_convert;
    assign read       = r_read;
    assign rowSel     = r_rowsel;
    assign count      = r_count;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb_pixel_frame_ctrl: scoreboard bench for pixel_frame_ctrl at default parameters.
// A frame-position model computes the expected output word for each cycle.
module tb_pixel_frame_ctrl;

    localparam int EC    = 5;
    localparam int XC    = 255;
    localparam int CW    = 8;
    localparam int NR    = 2;
    localparam int RC    = 2;
    localparam int FRAME = EC + XC + (1 << CW) + NR * RC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          busy, erase, expose, convert, read, frame_done;
    logic [NR-1:0] rowSel;
    logic [CW-1:0] count;

    int n_chk = 0;
    int n_err = 0;
    int done_seen = 0;

    logic [15:0] sb_q[$];

    int m_pos = 0;
    bit m_act = 0;
    bit m_done = 0;

    pixel_frame_ctrl #(
        .ERASE_CYCLES(EC), .EXPOSE_CYCLES(XC), .COUNTER_WIDTH(CW),
        .NUM_ROWS(NR), .ROW_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .busy(busy), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .rowSel(rowSel), .count(count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {busy, erase, expose, convert, read, rowSel, count, frame_done};
    endfunction

    // Expected outputs derived from the position inside the frame.
    function automatic logic [15:0] exp_vec();
        logic [CW-1:0] bin;
        logic [CW-1:0] c;
        logic [NR-1:0] rs;
        logic e, x, v, r;
        e = 0; x = 0; v = 0; r = 0; rs = '0; c = '0; bin = '0;
        if (m_act) begin
            if (m_pos < EC) e = 1;
            else if (m_pos < EC + XC) x = 1;
            else if (m_pos < EC + XC + (1 << CW)) begin
                v = 1;
                bin = CW'(m_pos - EC - XC);
            end else begin
                r = 1;
                bin = '1;
                rs = NR'(1 << ((m_pos - EC - XC - (1 << CW)) / RC));
            end
`ifdef PIXEL_CTRL_GRAY_COUNT_EN
            c = bin ^ (bin >> 1);
`else
            c = bin;
`endif
            if (e || x) c = '0;
        end
        return {m_act, e, x, v, r, rs, c, m_done};
    endfunction

    task automatic model_step();
        if (!reset) begin
            m_act = 0; m_pos = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (start) begin m_act = 1; m_pos = 0; end
            end else if (m_pos == FRAME - 1) begin
                m_done = 1;
                if (continuous) m_pos = 0;
                else m_act = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // Push the expectation for the coming edge, then pop and compare after it.
    task automatic tick(input string tag);
        logic [15:0] e;
        model_step();
        sb_q.push_back(exp_vec());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(tag, 32'(dut_vec()), 32'(e));
        end
        if (frame_done) done_seen++;
    endtask

    // Assert reset between edges and check the outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk(tag, 32'(dut_vec()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        // Outputs are cleared while reset is held from time zero.
        #2;
        chk("reset_init", 32'(dut_vec()), 32'd0);
        tick("reset_hold");
        #2 reset = 1'b1;
        for (int i = 0; i < 20; i++) tick("idle");

        // Single frame: start seen at a single edge.
        done_seen = 0;
        start = 1'b1;
        tick("single");
        start = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) tick("single");
        chk("single_done_cnt", 32'(done_seen), 32'd1);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Continuous mode: back-to-back frames with no idle cycle.
        done_seen = 0;
        continuous = 1'b1;
        start = 1'b1;
        tick("cont");
        start = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) tick("cont");
        chk("cont_done_cnt", 32'(done_seen), 32'd3);
        continuous = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) tick("cont_end");
        chk("cont_done_total", 32'(done_seen), 32'd4);

        // A start pulse while busy is dropped.
        done_seen = 0;
        start = 1'b1;
        tick("busy_start");
        start = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            start = (m_act && (m_pos == 100 || m_pos == FRAME - 3)) ? 1'b1 : 1'b0;
            tick("busy_start");
        end
        start = 1'b0;
        chk("busy_done_cnt", 32'(done_seen), 32'd1);

        // Reset in mid-CONVERT aborts the frame and produces no frame_done.
        done_seen = 0;
        start = 1'b1;
        tick("rst_conv");
        start = 1'b0;
        for (int i = 0; i < EC + XC + 100 - 1; i++) tick("rst_conv");
        chk("rst_conv_count", 32'(count), 32'(exp_vec() & 16'h01FE) >> 1);
        async_reset("rst_conv_async");
        for (int i = 0; i < 3; i++) tick("rst_conv_hold");
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) tick("rst_conv_idle");
        chk("rst_conv_no_done", 32'(done_seen), 32'd0);
        start = 1'b1;
        tick("rst_refr");
        start = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) tick("rst_refr");
        chk("rst_refr_done", 32'(done_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
